// File: rtl/dff_bank_arbiter.sv
// Four-requester arbiter that owns one shared WIDTH-bit register, loads the winner's lane and holds it
// for a bounded window. Define DFF_ARB_FIXED_PRIORITY_EN for lowest-index-wins selection instead of round-robin.
module dff_bank_arbiter #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   wr_data,
    output logic [3:0]           grant,
    output logic                 ack,
    output logic                 busy,
    output logic [WIDTH-1:0]     q,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       owner;
    logic [1:0]       winner;
    logic [7:0]       hold_cnt;
    logic             hold_done;
    logic [WIDTH-1:0] lane;

    assign fsm_state = state;
    assign lane      = wr_data[owner*WIDTH +: WIDTH];
    assign hold_done = !req[owner] || (hold_cnt == 8'd0);

`ifdef DFF_ARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = 2'd0;
        if (req[0])      winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else if (req[2]) winner = 2'd2;
        else if (req[3]) winner = 2'd3;
    end
`else
    logic [1:0] ptr;

    // Search starts at ptr and wraps 3->0; 2-bit addition gives the wrap for free.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req != 4'd0) next_state = GRANT;
            GRANT:   next_state = HOLD;
            HOLD:    if (hold_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered so no path exists from req/wr_data to any port.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant    <= 4'd0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            q        <= '0;
            owner    <= 2'd0;
            hold_cnt <= 8'd0;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
            ptr      <= 2'd0;
`endif
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 4'd0) begin
                        grant <= 4'b0001 << winner;
                        busy  <= 1'b1;
                        owner <= winner;
                    end
                end
                GRANT: begin
                    q        <= lane;
                    ack      <= 1'b1;
                    hold_cnt <= 8'(HOLD_CYCLES - 1);
                end
                HOLD: begin
                    if (hold_done) begin
                        grant <= 4'd0;
                        busy  <= 1'b0;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
                        ptr   <= owner + 2'd1;
`endif
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    grant <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios plus random traffic, every cycle compared against
// an ownership-based reference model.
module tb_dff_bank_arbiter;

    localparam int W    = 8;
    localparam int HOLD = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [4*W-1:0]   wr_data;
    logic [3:0]       grant;
    logic             ack;
    logic             busy;
    logic [W-1:0]     q;
    logic [1:0]       fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: who owns the register and for how many cycles grant has been visible.
    int         m_owner = -1;
    int         m_age   = 0;
    int         m_ptr   = 0;
    logic [W-1:0] m_q   = '0;
    logic       m_ack   = 1'b0;

    dff_bank_arbiter #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wr_data   (wr_data),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy),
        .q         (q),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int pick(input logic [3:0] r, input int p);
        int w;
        w = -1;
`ifdef DFF_ARB_FIXED_PRIORITY_EN
        for (int k = 3; k >= 0; k--) if (r[k]) w = k;
`else
        for (int k = 0; k < 4; k++) if (w < 0 && r[(p + k) % 4]) w = (p + k) % 4;
`endif
        return w;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_q = '0; m_ack = 1'b0;
        end else if (m_owner < 0) begin
            m_ack = 1'b0;
            if (req != 4'd0) begin
                m_owner = pick(req, m_ptr);
                m_age   = 1;
            end
        end else if (m_age == 1) begin
            m_q   = wr_data[m_owner*W +: W];
            m_ack = 1'b1;
            m_age = 2;
        end else begin
            m_ack = 1'b0;
            if (!req[m_owner] || m_age == HOLD + 1) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0] exp_grant;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        exp_grant = (m_owner < 0) ? 4'd0 : (4'b0001 << m_owner);
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("ack",   32'(ack),   32'(m_ack));
        chk("busy",  32'(busy),  32'(exp_grant != 4'd0));
        chk("q",     32'(q),     32'(m_q));
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] v);
        wr_data[i*W +: W] = v;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    initial begin
        int ack_cyc[$];
        logic [W-1:0] ack_q[$];
        logic [W-1:0] fair_exp[5];
        int grant_cycles;

        reset   = 1'b1;
        req     = 4'b1111;
        wr_data = '0;

        // Reset held with every request active.
        do_reset(2);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_q",     32'(q),     32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        step();
        chk("first_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        do_reset(1);

        // Single requester on lane 2.
        set_lane(2, 8'hA5);
        req = 4'b0100;
        step();
        chk("single_grant", 32'(grant), 32'b0100);
        step();
        chk("single_q",   32'(q),   32'hA5);
        chk("single_ack", 32'(ack), 32'd1);
        set_lane(2, 8'h5A);
        grant_cycles = 2;
        for (int i = 0; i < 10 && grant != 4'd0; i++) begin
            step();
            if (grant != 4'd0) grant_cycles++;
        end
        chk("single_window", 32'(grant_cycles), 32'(HOLD + 1));
        chk("single_q_held", 32'(q), 32'hA5);
        step();
        chk("single_regrant", 32'(grant), 32'b0100);
        req = 4'b0000;
        do_reset(1);

`ifndef DFF_ARB_FIXED_PRIORITY_EN
        // Fairness: all four held, each lane taken in turn.
        fair_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
        for (int i = 0; i < 4; i++) set_lane(i, 8'(8'h10 * (i + 1)));
        req = 4'b1111;
        for (int i = 0; i < 40 && ack_q.size() < 5; i++) begin
            step();
            if (ack) begin
                ack_q.push_back(q);
                ack_cyc.push_back(cyc);
            end
        end
        chk("fair_count", 32'(ack_q.size()), 32'd5);
        for (int i = 0; i < ack_q.size(); i++) chk("fair_q", 32'(ack_q[i]), 32'(fair_exp[i]));
        for (int i = 1; i < ack_cyc.size(); i++)
            chk("fair_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(HOLD + 2));
        req = 4'b0000;
        do_reset(1);
`else
        // Fixed priority: requester 1 always beats requester 3.
        req = 4'b1010;
        set_lane(1, 8'h11);
        set_lane(3, 8'h33);
        for (int i = 0; i < 30; i++) begin
            step();
            if (grant != 4'd0) chk("fp_owner", 32'(grant), 32'b0010);
        end
        req = 4'b0000;
        do_reset(1);
`endif

        // Early release during the second HOLD cycle.
        req = 4'b0001;
        set_lane(0, 8'h77);
        step();
        step();
        step();
        chk("early_busy_hold", 32'(busy), 32'd1);
        req = 4'b0000;
        step();
        chk("early_grant", 32'(grant), 32'd0);
        chk("early_busy",  32'(busy),  32'd0);
        chk("early_q",     32'(q),     32'h77);

        // Reset in the middle of HOLD.
        req = 4'b0010;
        set_lane(1, 8'h3C);
        step();
        step();
        step();
        chk("midhold_grant", 32'(grant), 32'b0010);
        chk("midhold_q",     32'(q),     32'h3C);
        do_reset(1);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_q",     32'(q),     32'd0);
        req = 4'b1111;
        step();
        chk("midrst_ptr", 32'(grant), 32'b0001);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) set_lane($urandom_range(0, 3), 8'($urandom));
            reset = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit synchronous-reset register among four requesters. Each requester presents data and a request. The block grants exactly one requester at a time, loads that requester's data into the shared register, and holds ownership for a bounded window before re-arbitrating. It sits between the board-level requester logic (switch/button handlers) and the shared output register driving LEDs or downstream logic.

## Interface
- WIDTH, 8, width of shared register and of each requester's data lane
- HOLD_CYCLES, 4, maximum cycles a requester owns the register after the load; legal range 1..255

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- req  input  4  request per requester; bit i = requester i
- wr_data  input  4*WIDTH  requester data lanes; lane i = wr_data[i*WIDTH +: WIDTH]
- grant  output  4  one-hot ownership indication, registered; 0 when idle
- ack  output  1  one-cycle pulse in the cycle q first shows newly loaded data
- busy  output  1  high while in GRANT or HOLD
- q  output  WIDTH  shared register contents

## Operation
- Reset (synchronous, active-high) is sampled on posedge clk. It forces: state IDLE, grant=0, ack=0, busy=0, q=0, rr pointer=0, hold counter=0. Reset overrides every other event, including mid-HOLD.
- State machine:
  - IDLE, when req==0: stay in IDLE; q holds its value.
  - IDLE, when req!=0: go to GRANT. grant is set to the one-hot winner, and the owner index is latched.
  - GRANT: on the next edge, q <= lane[owner], ack <= 1, hold counter <= HOLD_CYCLES-1, and the state goes to HOLD. This transition is unconditional, even if req[owner] drops during GRANT.
  - HOLD: grant and q are stable and ack=0.
    - Exit to IDLE when req[owner]==0 (early release) or when hold counter==0. Otherwise decrement the counter.
    - On exit: grant <= 0 and pointer <= (owner+1) mod 4.
- Round-robin selection: search req bits starting at the pointer and wrapping 3→0. The first set bit wins. The pointer changes only on HOLD exit.
- In HOLD, q is not reloaded. Changes on wr_data for any lane are ignored until the next GRANT.
- Requests arriving during GRANT or HOLD wait. They are evaluated in the first IDLE cycle after release.
- At most one grant bit is ever set. busy == (grant != 0).

## Timing
- Request to grant: req sampled at edge E while in IDLE, grant visible after E (1 cycle).
- Grant to load: q updates and ack pulses after edge E+1 (2 cycles from request sample).
- Ownership window: grant high for 1 (GRANT) + HOLD_CYCLES cycles maximum. Early release ends HOLD at the first edge where req[owner]==0.
- Turnaround: at least one IDLE cycle between consecutive grants. A continuously requesting set of requesters therefore sees one grant every HOLD_CYCLES+2 cycles.
- Simultaneous reset with any req or state exit: reset wins, and all outputs are 0 on the next cycle.
- All outputs are registered. No combinational path from req or wr_data to any output.

## Configuration
- DFF_ARB_FIXED_PRIORITY_EN
  - Defined: selection is fixed priority, and the lowest-index set req bit always wins. The rr pointer is removed; all other behaviour is unchanged.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: apply reset for 2 cycles with req=4'b1111 -> grant=0, q=0, ack=0, busy=0. First grant after release goes to requester 0.
- Single requester: WIDTH=8, req=4'b0100, lane2=8'hA5 -> grant=4'b0100 after 1 cycle, then q=8'hA5 with one-cycle ack. grant drops after HOLD_CYCLES=4 cycles with req held, then one IDLE cycle. On the next arbitration with only req[2] high, 4'b0100 is granted again.
- Fairness: req=4'b1111 held, lanes 8'h10/8'h20/8'h30/8'h40 -> q sequence 10,20,30,40,10. Grants are 6 cycles apart.
- Early release: req=4'b0001, drop req[0] on the second HOLD cycle -> grant clears at that edge, and busy=0 in the next cycle.
- Reset mid-HOLD: assert reset while grant=4'b0010 and q=8'h3C -> next cycle grant=0, q=8'h00, pointer back to 0.
- With DFF_ARB_FIXED_PRIORITY_EN defined, req=4'b1010 held -> requester 1 wins every arbitration and requester 3 is never granted.
